// File: rtl/pong_pkg.sv
// Shared playfield defaults and the paddle direction encoding for the pong paddle controller.
package pong_pkg;

   localparam int DEF_SCREEN_H = 480;
   localparam int DEF_PADDLE_H = 80;
   localparam int DEF_STEP     = 4;
   localparam int DEF_Y_MAX    = DEF_SCREEN_H - DEF_PADDLE_H;
   localparam int DEF_Y_MID    = DEF_Y_MAX / 2;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2
   } dir_e;

   // Opposing presses cancel so a paddle never jitters when both keys are down.
   function automatic dir_e resolve_dir(input logic up, input logic down);
      if (up && !down)      return DIR_UP;
      else if (down && !up) return DIR_DOWN;
      else                  return DIR_NONE;
   endfunction

endpackage

// File: rtl/pong_paddle_axis.sv
// One paddle: up/down hold-off timers, direction resolution, saturating y register and moving flag.
module pong_paddle_axis
   import pong_pkg::*;
#(
   parameter int HOLD_TICKS = 8,
   parameter int Y_W        = 10,
   parameter int STEP       = DEF_STEP,
   parameter int Y_MAX      = DEF_Y_MAX,
   parameter int Y_MID      = DEF_Y_MID
) (
   input  logic           clk25MHz,
   input  logic           rst,
   input  logic           tick,
   input  logic           btn_up,
   input  logic           btn_down,
   output logic [Y_W-1:0] y,
   output logic           moving
);

   localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

   logic [HW-1:0]  hold_up;
   logic [HW-1:0]  hold_down;
   logic           up_eff;
   logic           down_eff;
   dir_e           dir;
   logic [Y_W-1:0] y_next;

   function automatic logic [HW-1:0] hold_next(input logic btn, input logic tk,
                                               input logic [HW-1:0] cnt);
      if (btn)                  return HW'(HOLD_TICKS);
      else if (tk && cnt != '0) return cnt - HW'(1);
      else                      return cnt;
   endfunction

   function automatic logic [Y_W-1:0] sat_up(input logic [Y_W-1:0] cur);
      if (cur < Y_W'(STEP)) return '0;
      else                  return cur - Y_W'(STEP);
   endfunction

   // The sum carries one extra bit so a step near the bottom edge cannot wrap.
   function automatic logic [Y_W-1:0] sat_down(input logic [Y_W-1:0] cur);
      logic [Y_W:0] sum;
      sum = {1'b0, cur} + (Y_W+1)'(STEP);
      if (sum > (Y_W+1)'(Y_MAX)) return Y_W'(Y_MAX);
      else                       return sum[Y_W-1:0];
   endfunction

   always_comb begin
      up_eff   = btn_up   | (hold_up   != '0);
      down_eff = btn_down | (hold_down != '0);
      dir      = resolve_dir(up_eff, down_eff);
      y_next   = y;
      case (dir)
         DIR_UP:   y_next = sat_up(y);
         DIR_DOWN: y_next = sat_down(y);
         default:  y_next = y;
      endcase
   end

   always_ff @(posedge clk25MHz) begin
      if (rst) begin
         hold_up   <= '0;
         hold_down <= '0;
         y         <= Y_W'(Y_MID);
         moving    <= 1'b0;
      end else begin
         hold_up   <= hold_next(btn_up, tick, hold_up);
         hold_down <= hold_next(btn_down, tick, hold_down);
         if (tick) begin
            y      <= y_next;
            moving <= (y_next != y);
         end
      end
   end

endmodule

// File: rtl/pong_paddle_ctrl.sv
// Turns keyboard button levels into two paddle positions, paced by a frame-rate tick divider.
module pong_paddle_ctrl
   import pong_pkg::*;
#(
   parameter int TICK_DIV   = 416667,
   parameter int SCREEN_H   = DEF_SCREEN_H,
   parameter int PADDLE_H   = DEF_PADDLE_H,
   parameter int STEP       = DEF_STEP,
   parameter int HOLD_TICKS = 8,
   parameter int Y_W        = 10
) (
   input  logic           clk25MHz,
   input  logic           rst,
   input  logic           btn1,
   input  logic           btn2,
   input  logic           btn3,
   input  logic           btn4,
   output logic           frame_tick,
   output logic [Y_W-1:0] paddle1_y,
   output logic [Y_W-1:0] paddle2_y,
   output logic           paddle1_moving,
   output logic           paddle2_moving
);

   localparam int Y_MAX = SCREEN_H - PADDLE_H;
   localparam int Y_MID = Y_MAX / 2;
   localparam int CW    = $clog2(TICK_DIV);

   logic [CW-1:0] tick_cnt;

   // frame_tick is registered off the terminal count, so its period is exactly TICK_DIV.
   always_ff @(posedge clk25MHz) begin
      if (rst) begin
         tick_cnt   <= '0;
         frame_tick <= 1'b0;
      end else if (tick_cnt == CW'(TICK_DIV - 1)) begin
         tick_cnt   <= '0;
         frame_tick <= 1'b1;
      end else begin
         tick_cnt   <= tick_cnt + CW'(1);
         frame_tick <= 1'b0;
      end
   end

   pong_paddle_axis #(
      .HOLD_TICKS (HOLD_TICKS),
      .Y_W        (Y_W),
      .STEP       (STEP),
      .Y_MAX      (Y_MAX),
      .Y_MID      (Y_MID)
   ) u_paddle1 (
      .clk25MHz (clk25MHz),
      .rst      (rst),
      .tick     (frame_tick),
      .btn_up   (btn2),
      .btn_down (btn1),
      .y        (paddle1_y),
      .moving   (paddle1_moving)
   );

   pong_paddle_axis #(
      .HOLD_TICKS (HOLD_TICKS),
      .Y_W        (Y_W),
      .STEP       (STEP),
      .Y_MAX      (Y_MAX),
      .Y_MID      (Y_MID)
   ) u_paddle2 (
      .clk25MHz (clk25MHz),
      .rst      (rst),
      .tick     (frame_tick),
      .btn_up   (btn4),
      .btn_down (btn3),
      .y        (paddle2_y),
      .moving   (paddle2_moving)
   );

endmodule
